// File: rtl/baccarat_dealer.sv
// -----------------------------------------------------------------------------
// baccarat_dealer
// Sequencing controller for one baccarat round. Issues one-hot card-load
// strobes to the player/banker hand registers (one card per step), applies
// the third-card rules using the scorer outputs, then declares the winner.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset, priority over step
//   step        advance request, one state per high cycle
//   pscore      player hand score 0..9 (combinational from scorer)
//   dscore      banker hand score 0..9 (combinational from scorer)
//   pcard3      player third-card raw rank 1..13
//   load_pcard  player card load enables, bit i loads card i+1 (Mealy)
//   load_dcard  banker card load enables, same encoding (Mealy)
//   player_win  pscore > dscore, or tie; valid while done
//   dealer_win  dscore > pscore, or tie; valid while done
//   done        round complete (state RESULT)
// -----------------------------------------------------------------------------
module baccarat_dealer (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic [2:0] load_pcard,
    output logic [2:0] load_dcard,
    output logic       player_win,
    output logic       dealer_win,
    output logic       done
);

    localparam int unsigned SCORE_W = 4;

    typedef enum logic [3:0] {
        DEAL_P1    = 4'd0,
        DEAL_D1    = 4'd1,
        DEAL_P2    = 4'd2,
        DEAL_D2    = 4'd3,
        CHECK      = 4'd4,
        DEAL_P3    = 4'd5,
        BANKER_DEC = 4'd6,
        DEAL_D3    = 4'd7,
        RESULT     = 4'd8
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [SCORE_W-1:0] pcard3_val;
    logic               banker_draw;
    logic               natural;

    // Face cards and tens count as zero in baccarat.
    assign pcard3_val = (pcard3 > SCORE_W'(9)) ? SCORE_W'(0) : pcard3;

    assign natural = (pscore >= SCORE_W'(8)) || (dscore >= SCORE_W'(8));

    // Banker third-card table, indexed by banker score and player's third card.
    always_comb begin
        banker_draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
            4'd3:             banker_draw = (pcard3_val != SCORE_W'(8));
            4'd4:             banker_draw = (pcard3_val >= SCORE_W'(2)) && (pcard3_val <= SCORE_W'(7));
            4'd5:             banker_draw = (pcard3_val >= SCORE_W'(4)) && (pcard3_val <= SCORE_W'(7));
            4'd6:             banker_draw = (pcard3_val >= SCORE_W'(6)) && (pcard3_val <= SCORE_W'(7));
            default:          banker_draw = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DEAL_P1;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and outputs; strobes are suppressed during reset.
    always_comb begin
        state_d    = state_q;
        load_pcard = 3'b000;
        load_dcard = 3'b000;
        done       = 1'b0;
        player_win = 1'b0;
        dealer_win = 1'b0;

        case (state_q)
            DEAL_P1: if (step) begin
                load_pcard[0] = ~reset;
                state_d       = DEAL_D1;
            end
            DEAL_D1: if (step) begin
                load_dcard[0] = ~reset;
                state_d       = DEAL_P2;
            end
            DEAL_P2: if (step) begin
                load_pcard[1] = ~reset;
                state_d       = DEAL_D2;
            end
            DEAL_D2: if (step) begin
                load_dcard[1] = ~reset;
                state_d       = CHECK;
            end
            CHECK: if (step) begin
                if (natural) begin
                    state_d = RESULT;
                end else if (pscore <= SCORE_W'(5)) begin
                    state_d = DEAL_P3;
                end else if (dscore <= SCORE_W'(5)) begin
                    state_d = DEAL_D3;
                end else begin
                    state_d = RESULT;
                end
            end
            DEAL_P3: if (step) begin
                load_pcard[2] = ~reset;
                state_d       = BANKER_DEC;
            end
            BANKER_DEC: if (step) begin
                state_d = banker_draw ? DEAL_D3 : RESULT;
            end
            DEAL_D3: if (step) begin
                load_dcard[2] = ~reset;
                state_d       = RESULT;
            end
            RESULT: begin
                // Terminal; scores are stable since no further loads occur.
                done       = ~reset;
                player_win = ~reset & (pscore >= dscore);
                dealer_win = ~reset & (dscore >= pscore);
            end
            default: state_d = DEAL_P1;
        endcase
    end

endmodule

// File: doc/baccarat_dealer.md
# baccarat_dealer

Sequencing controller for the baccarat datapath. It produces the one-hot card-load strobes that feed the player and banker hand registers, one card per `step`. It reads back the hand scores to apply the third-card rules, then declares the winner. It sits between the card source / step debouncer and the hand registers plus hand scorers.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high; returns the FSM to `DEAL_P1`; has priority over `step`.
- `step` in 1: advance request; sampled every edge; each cycle it is high counts as one step.
- `pscore` in 4: player hand score 0..9, combinational from the scorer, reflecting the loaded cards.
- `dscore` in 4: banker hand score 0..9, same source rules as `pscore`.
- `pcard3` in 4: player third card raw rank 1..13, as held in the hand register.
- `load_pcard` out 3: player card load enables; bit i loads card i+1; at most one bit high.
- `load_dcard` out 3: banker card load enables; same encoding.
- `player_win` out 1: player score exceeds banker score; valid only while `done`.
- `dealer_win` out 1: banker score exceeds player score; valid only while `done`. Both high indicates a tie.
- `done` out 1: round complete.

## Operation
- States: `DEAL_P1`, `DEAL_D1`, `DEAL_P2`, `DEAL_D2`, `CHECK`, `DEAL_P3`, `BANKER_DEC`, `DEAL_D3`, `RESULT`. Encoding is free.
- Load strobes are Mealy outputs, equal to `step & (state == X) & ~reset`:
  - `DEAL_P1` drives `load_pcard[0]`; `DEAL_D1` drives `load_dcard[0]`.
  - `DEAL_P2` drives `load_pcard[1]`; `DEAL_D2` drives `load_dcard[1]`.
  - `DEAL_P3` drives `load_pcard[2]`; `DEAL_D3` drives `load_dcard[2]`.
  - All other states drive zero.
- Each strobe is accompanied by a transition on the same edge. The fixed order is `DEAL_P1` → `DEAL_D1` → `DEAL_P2` → `DEAL_D2` → `CHECK`.
- `CHECK` (no load), on step:
  - If `pscore` ≥ 8 or `dscore` ≥ 8 (natural), go to `RESULT`.
  - Else if `pscore` ≤ 5, go to `DEAL_P3`.
  - Else (`pscore` is 6 or 7): if `dscore` ≤ 5, go to `DEAL_D3`; otherwise go to `RESULT`.
- `DEAL_P3`, on step: go to `BANKER_DEC`. `pcard3` becomes valid from the next cycle.
- `BANKER_DEC` (no load), on step: compute v = (`pcard3` > 9) ? 0 : `pcard3`. The banker draws when any of the following holds:
  - `dscore` ≤ 2.
  - `dscore` = 3 and v ≠ 8.
  - `dscore` = 4 and 2 ≤ v ≤ 7.
  - `dscore` = 5 and 4 ≤ v ≤ 7.
  - `dscore` = 6 and 6 ≤ v ≤ 7.
  - When the banker draws, go to `DEAL_D3`; otherwise go to `RESULT`.
- `DEAL_D3`, on step: go to `RESULT`.
- `RESULT` is terminal. `step` is ignored and no strobes are issued. Exit is by `reset` only.
- While in `RESULT`:
  - `done` = 1.
  - `player_win` = (`pscore` > `dscore`).
  - `dealer_win` = (`dscore` > `pscore`).
  - On equal scores, both are 1.
  - Score inputs are stable here because no further loads occur.
- Comparisons are unsigned 4-bit. Score inputs above 9 are outside the contract, and the decision result is then don't-care.

## Timing
- Reset values: state `DEAL_P1`; `load_pcard` = 0, `load_dcard` = 0, `player_win` = 0, `dealer_win` = 0, `done` = 0.
- During the reset cycle all strobes are 0, even with `step` high.
- One state transition per step cycle. `step` held high for N cycles advances N states.
- The load strobe and the hand-register capture share one edge. The scorer output reflects the new card from the following cycle.
- Decision states (`CHECK`, `BANKER_DEC`) each consume one step. They read scores that are already stable, so there is no same-edge dependency on a card being loaded.
- `done`, `player_win` and `dealer_win` become valid the cycle after the transition into `RESULT`, and hold until reset.
- Round length:
  - Natural: 5 steps.
  - Both stand: 5 steps.
  - Player stands, banker draws: 6 steps.
  - Player draws, banker stands: 7 steps.
  - Both draw: 8 steps.
- Reset mid-round from any state: `DEAL_P1` on the next edge. Outputs are zero that cycle. Hand registers are cleared by the same `reset` externally.

## Test plan
- Natural: four steps loading cards to reach `pscore`=8, `dscore`=3, then one step in `CHECK` → next cycle `RESULT`, `done`=1, `player_win`=1, `dealer_win`=0. No `*card[2]` strobe ever seen.
- Player stands, banker draws: `pscore`=6, `dscore`=4 → `CHECK` step goes to `DEAL_D3`. Next step pulses `load_dcard[2]` exactly one cycle; `done` follows; total 6 steps.
- Banker rule with `pcard3`=8 and `dscore`=3: after `DEAL_P3` and a `BANKER_DEC` step → `RESULT` with no `load_dcard[2]`. Repeat with `pcard3`=12 (v=0) → `DEAL_D3`.
- Tie: final `pscore`=`dscore`=7 → `player_win`=1 and `dealer_win`=1 with `done`=1. Further `step` pulses produce no strobes and no state change.
- Held step: `step` high 4 consecutive cycles after reset → `load_pcard[0]`, `load_dcard[0]`, `load_pcard[1]`, `load_dcard[1]` on successive cycles, each exactly one cycle wide.
- Reset mid-round: `reset` and `step` both high while in `DEAL_P3` → no `load_pcard[2]`. State is `DEAL_P1` next cycle and `done`=0; the next step pulses `load_pcard[0]`.
